cache_stats_collector: RTL and testbench
========================================

Name: cache_stats_collector

Overview:
- Synthesizable, parametrised event-statistics unit for the L2 cache: counts per-cycle event strobes (hit, miss, read, write, and any added later) on N channels.
- Supports saturating or wrapping counters, sticky overflow flags, and a snapshot bank read through a valid/ready port.
- Optional fixed-length sampling windows auto-snapshot and restart the counters.
- Sits beside L2Cache, driven by its hit/miss/read/write outputs; it replaces ad-hoc integer counting in benches.

Parameters:
- NUM_EVENTS, 4, number of event channels (index order defined in package).
- COUNT_WIDTH, 32, width of each counter.
- SATURATE, 1, 1 = counters stick at all-ones; 0 = counters wrap to 0.
- WINDOW_CYCLES, 0, sampling window length in cycles; 0 disables windowing.
- IDX_W, $clog2(NUM_EVENTS) (min 1), read index width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- event_in  in  NUM_EVENTS  per-channel event strobe, one count per cycle when high.
- enable  in  1  global count enable.
- clear  in  1  zero live counters, overflow flags and window timer.
- snapshot_req  in  1  copy live counters into snapshot bank.
- rd_req  in  1  read request.
- rd_index  in  IDX_W  channel to read.
- rd_ready  out  1  request accepted when rd_req && rd_ready.
- rd_data  out  COUNT_WIDTH  snapshot value.
- rd_err  out  1  index >= NUM_EVENTS, qualified by rd_data_valid.
- rd_data_valid  out  1  response valid.
- rd_data_ready  in  1  consumer takes response.
- overflow  out  NUM_EVENTS  sticky per-channel overflow.
- window_done  out  1  one-cycle pulse at automatic window snapshot.

Behaviour:
- Reset: live counters, snapshot bank, overflow, rd_data, rd_err, rd_data_valid, window_done and window timer are all 0. rd_ready is 1 in the cycle after reset.
- Increment: live[i] += 1 on a cycle with enable && event_in[i]. Result visible the next cycle.
- SATURATE=1: at all-ones, live[i] holds and overflow[i] sets.
- SATURATE=0: all-ones + 1 gives 0, and overflow[i] sets.
- overflow is sticky until clear or reset.
- Clear priority: clear beats increment in the same cycle, so live = 0 (not 1). Clear also zeroes overflow and the window timer; the snapshot bank is untouched.
- Snapshot: snap[i] <= registered live[i], excluding the same-cycle event.
  - clear + snapshot_req in the same cycle: snapshot captures the pre-clear value, and live becomes 0.
- Window mode (WINDOW_CYCLES>0):
  - Timer counts every cycle regardless of enable, 0..WINDOW_CYCLES-1.
  - At terminal count: auto snapshot, window_done pulses next cycle, timer wraps to 0.
  - Live[i] reloads with (enable && event_in[i]), i.e. the boundary cycle's event counts into the new window.
  - Overflow flags clear at the boundary.
  - snapshot_req coinciding with the boundary has the same effect as a single snapshot.
  - clear coinciding with the boundary: clear wins; no snapshot, no window_done.
- Read port:
  - rd_ready = !rd_data_valid || rd_data_ready.
  - Accepted request gives rd_data_valid=1 the next cycle, with rd_data = snap[rd_index].
  - rd_data, rd_err and rd_data_valid hold stable until rd_data_ready; back-to-back reads give 1 response/cycle.
  - Out-of-range index: rd_data=0, rd_err=1.
  - A read in the same cycle as a snapshot returns the old snapshot value.
- Reset mid-read: the response is dropped and rd_data_valid goes to 0.

Decomposition:
- Package cache_stats_pkg:
  - event index constants EV_HIT=0, EV_MISS=1, EV_READ=2, EV_WRITE=3, NUM_CACHE_EVENTS=4;
  - typedef stat_count_t (logic [31:0]).
- Sub-module stat_counter: one channel, covering increment, clear, reload, saturate/wrap and sticky overflow.
- The top instantiates NUM_EVENTS stat_counters plus the window timer, snapshot bank and read port.

Test Plan:
- Basic count: reset, enable=1, pulse event_in=4'b0001 5 cycles and 4'b0100 3 cycles, snapshot, read idx 0 and 2 -> rd_data 5 and 3; idx 1 -> 0, rd_err=0.
- Saturate/wrap: COUNT_WIDTH=4, 17 hits -> SATURATE=1: 15, overflow[0]=1; SATURATE=0: 1, overflow[0]=1; then clear -> 0, overflow=0.
- Clear priority: clear and event_in[0] in the same cycle as snapshot_req with live=7 -> snapshot 7, live 0 next cycle.
- Window: WINDOW_CYCLES=10, hit every cycle -> window_done every 10 cycles. First snapshot = 9; each later snapshot = 10.
- Read handshake: hold rd_data_ready=0 for 3 cycles -> rd_data stable, rd_ready=0. Index 5 with NUM_EVENTS=4 -> rd_err=1, rd_data=0.
- Reset mid-operation: assert reset with rd_data_valid=1 and live=20 -> all outputs 0 next cycle, rd_ready=1.

Source files
------------

// File: rtl/cache_stats_collector_pkg.sv
// Shared definitions for the L2 cache statistics collector: event channel
// indices, the default counter type and a helper for read-index width.
package cache_stats_pkg;

  // Event channel order as wired from L2Cache.
  localparam int EV_HIT           = 0;
  localparam int EV_MISS          = 1;
  localparam int EV_READ          = 2;
  localparam int EV_WRITE         = 3;
  localparam int NUM_CACHE_EVENTS = 4;

  typedef logic [31:0] stat_count_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int indexWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_stats_collector_if.sv
// Bundle of event, control and snapshot-read signals for the statistics
// collector.
//
// Read handshake: a request is accepted on a rising clock edge where
// rd_req && rd_ready. The response appears the following cycle with
// rd_data_valid = 1, and rd_data / rd_err / rd_data_valid hold stable until
// a rising edge where rd_data_valid && rd_data_ready, at which point it is
// consumed. rd_ready = !rd_data_valid || rd_data_ready, so a consumer that
// keeps rd_data_ready high sustains one response per cycle.
interface cache_stats_if
  import cache_stats_pkg::*;
#(
  parameter int NUM_EVENTS  = NUM_CACHE_EVENTS,
  parameter int COUNT_WIDTH = 32,
  parameter int IDX_W       = indexWidth(NUM_EVENTS)
);

  logic [NUM_EVENTS-1:0]  event_in;
  logic                   enable;
  logic                   clear;
  logic                   snapshot_req;
  logic                   rd_req;
  logic [IDX_W-1:0]       rd_index;
  logic                   rd_ready;
  logic [COUNT_WIDTH-1:0] rd_data;
  logic                   rd_err;
  logic                   rd_data_valid;
  logic                   rd_data_ready;
  logic [NUM_EVENTS-1:0]  overflow;
  logic                   window_done;

  // Event source / read consumer side.
  modport master (
    output event_in, enable, clear, snapshot_req, rd_req, rd_index, rd_data_ready,
    input  rd_ready, rd_data, rd_err, rd_data_valid, overflow, window_done
  );

  // Collector side.
  modport slave (
    input  event_in, enable, clear, snapshot_req, rd_req, rd_index, rd_data_ready,
    output rd_ready, rd_data, rd_err, rd_data_valid, overflow, window_done
  );

endinterface

// File: rtl/cache_stats_collector_stat_counter.sv
// One live event counter: clear, window reload, saturating or wrapping
// increment and a sticky overflow flag.
module stat_counter #(
  parameter int COUNT_WIDTH = 32,
  parameter bit SATURATE    = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   reload,
  input  logic                   inc,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   overflow
);

  logic atMax;

  assign atMax = (count == '1);

  // Clear dominates everything; a window reload starts the new window with
  // this cycle's event; otherwise count up, holding or wrapping at all-ones.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (reload) begin
      count    <= COUNT_WIDTH'(inc);
      overflow <= 1'b0;
    end else if (inc) begin
      if (atMax) begin
        overflow <= 1'b1;
        if (!SATURATE) begin
          count <= '0;
        end
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_stats_collector.sv
// L2 cache event statistics collector: per-channel live counters, optional
// fixed-length sampling windows, a snapshot bank and a valid/ready read port.
module cache_stats_collector
  import cache_stats_pkg::*;
#(
  parameter int NUM_EVENTS    = NUM_CACHE_EVENTS,
  parameter int COUNT_WIDTH   = $bits(stat_count_t),
  parameter bit SATURATE      = 1'b1,
  parameter int WINDOW_CYCLES = 0,
  parameter int IDX_W         = indexWidth(NUM_EVENTS)
) (
  input logic          clock,
  input logic          reset,
  cache_stats_if.slave bus
);

  logic [COUNT_WIDTH-1:0] liveCount [NUM_EVENTS];
  logic [COUNT_WIDTH-1:0] snapBank  [NUM_EVENTS];
  logic [NUM_EVENTS-1:0]  overflowBits;

  logic windowEnd;
  logic windowBoundary;
  logic takeSnapshot;
  logic windowDone;

  logic                   rdReady;
  logic                   rdAccept;
  logic                   indexBad;
  logic [COUNT_WIDTH-1:0] rdMux;
  logic                   rdValid;
  logic                   rdErr;
  logic [COUNT_WIDTH-1:0] rdData;

  // A clear in the boundary cycle cancels the automatic snapshot and pulse.
  assign windowBoundary = windowEnd && !bus.clear;
  // An explicit request and a boundary in the same cycle are one snapshot.
  assign takeSnapshot   = bus.snapshot_req || windowBoundary;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_EVENTS; gi++) begin : gChannel
      stat_counter #(
        .COUNT_WIDTH (COUNT_WIDTH),
        .SATURATE    (SATURATE)
      ) uCounter (
        .clock    (clock),
        .reset    (reset),
        .clear    (bus.clear),
        .reload   (windowBoundary),
        .inc      (bus.enable && bus.event_in[gi]),
        .count    (liveCount[gi]),
        .overflow (overflowBits[gi])
      );
    end
  endgenerate

  generate
    if (WINDOW_CYCLES > 0) begin : gWindow
      localparam int TIMER_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

      logic [TIMER_W-1:0] windowTimer;

      assign windowEnd = (windowTimer == TIMER_W'(WINDOW_CYCLES - 1));

      // Window timer runs every cycle, independent of enable, and wraps at
      // the terminal count.
      always_ff @(posedge clock) begin
        if (reset || bus.clear) begin
          windowTimer <= '0;
        end else if (windowEnd) begin
          windowTimer <= '0;
        end else begin
          windowTimer <= windowTimer + 1'b1;
        end
      end
    end else begin : gNoWindow
      assign windowEnd = 1'b0;
    end
  endgenerate

  // One-cycle pulse following each automatic window snapshot.
  always_ff @(posedge clock) begin
    if (reset) begin
      windowDone <= 1'b0;
    end else begin
      windowDone <= windowBoundary;
    end
  end

  // Snapshot bank copies the registered live counts, so the event arriving
  // in the snapshot cycle (and any same-cycle clear) is not reflected.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (reset) begin
        snapBank[i] <= '0;
      end else if (takeSnapshot) begin
        snapBank[i] <= liveCount[i];
      end
    end
  end

  // Snapshot read mux; an index beyond the last channel selects zero.
  always_comb begin
    rdMux = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (32'(bus.rd_index) == 32'(i)) begin
        rdMux = snapBank[i];
      end
    end
  end

  assign indexBad = (32'(bus.rd_index) >= 32'(NUM_EVENTS));
  assign rdReady  = !rdValid || bus.rd_data_ready;
  assign rdAccept = bus.rd_req && rdReady;

  // Single-entry response register: load on accept, drop on consume.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdValid <= 1'b0;
      rdData  <= '0;
      rdErr   <= 1'b0;
    end else if (rdAccept) begin
      rdValid <= 1'b1;
      rdData  <= rdMux;
      rdErr   <= indexBad;
    end else if (bus.rd_data_ready) begin
      rdValid <= 1'b0;
    end
  end

  assign bus.rd_ready      = rdReady;
  assign bus.rd_data       = rdData;
  assign bus.rd_err        = rdErr;
  assign bus.rd_data_valid = rdValid;
  assign bus.overflow      = overflowBits;
  assign bus.window_done   = windowDone;

endmodule

// File: tb/tb_cache_stats_collector.sv
// Bench for cache_stats_collector. Four instances share one stimulus set and
// are isolated by holding the idle ones in reset:
//   dutA: 8-bit saturating, no window   (counting, clear, read port, reset)
//   dutS: 4-bit saturating              (saturation and overflow)
//   dutR: 4-bit wrapping                (wrap and overflow)
//   dutW: 4-bit saturating, 10-cycle window
// Read responses of the selected instance are checked by a monitor against
// an expected queue of {rd_err, rd_data}.
module tb_cache_stats_collector;
  import cache_stats_pkg::*;

  logic clock;
  logic resetA, resetS, resetR, resetW;

  logic [3:0] ev;
  logic       en, clr, snapReq, rdReq, rdDataReady;
  logic [2:0] rdIdx;

  int sel;
  int checks = 0;
  int errors = 0;

  logic [8:0] expQ[$];

  logic       curValid, curErr;
  logic [7:0] curData;

  cache_stats_if #(.NUM_EVENTS(4), .COUNT_WIDTH(8), .IDX_W(3)) ifA ();
  cache_stats_if #(.NUM_EVENTS(4), .COUNT_WIDTH(4), .IDX_W(3)) ifS ();
  cache_stats_if #(.NUM_EVENTS(4), .COUNT_WIDTH(4), .IDX_W(3)) ifR ();
  cache_stats_if #(.NUM_EVENTS(4), .COUNT_WIDTH(4), .IDX_W(3)) ifW ();

  assign ifA.event_in = ev;      assign ifS.event_in = ev;
  assign ifR.event_in = ev;      assign ifW.event_in = ev;
  assign ifA.enable = en;        assign ifS.enable = en;
  assign ifR.enable = en;        assign ifW.enable = en;
  assign ifA.clear = clr;        assign ifS.clear = clr;
  assign ifR.clear = clr;        assign ifW.clear = clr;
  assign ifA.snapshot_req = snapReq; assign ifS.snapshot_req = snapReq;
  assign ifR.snapshot_req = snapReq; assign ifW.snapshot_req = snapReq;
  assign ifA.rd_req = rdReq;     assign ifS.rd_req = rdReq;
  assign ifR.rd_req = rdReq;     assign ifW.rd_req = rdReq;
  assign ifA.rd_index = rdIdx;   assign ifS.rd_index = rdIdx;
  assign ifR.rd_index = rdIdx;   assign ifW.rd_index = rdIdx;
  assign ifA.rd_data_ready = rdDataReady; assign ifS.rd_data_ready = rdDataReady;
  assign ifR.rd_data_ready = rdDataReady; assign ifW.rd_data_ready = rdDataReady;

  cache_stats_collector #(.NUM_EVENTS(4), .COUNT_WIDTH(8), .SATURATE(1'b1),
    .WINDOW_CYCLES(0), .IDX_W(3)) dutA (.clock(clock), .reset(resetA), .bus(ifA.slave));
  cache_stats_collector #(.NUM_EVENTS(4), .COUNT_WIDTH(4), .SATURATE(1'b1),
    .WINDOW_CYCLES(0), .IDX_W(3)) dutS (.clock(clock), .reset(resetS), .bus(ifS.slave));
  cache_stats_collector #(.NUM_EVENTS(4), .COUNT_WIDTH(4), .SATURATE(1'b0),
    .WINDOW_CYCLES(0), .IDX_W(3)) dutR (.clock(clock), .reset(resetR), .bus(ifR.slave));
  cache_stats_collector #(.NUM_EVENTS(4), .COUNT_WIDTH(4), .SATURATE(1'b1),
    .WINDOW_CYCLES(10), .IDX_W(3)) dutW (.clock(clock), .reset(resetW), .bus(ifW.slave));

  // Clock and watchdog.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t, required finish before it", $time);
    $fatal(1, "watchdog expired");
  end

  // Route the selected instance's read response to the monitor.
  always_comb begin
    curValid = ifA.rd_data_valid;
    curErr   = ifA.rd_err;
    curData  = ifA.rd_data;
    case (sel)
      1: begin curValid = ifS.rd_data_valid; curErr = ifS.rd_err; curData = {4'b0, ifS.rd_data}; end
      2: begin curValid = ifR.rd_data_valid; curErr = ifR.rd_err; curData = {4'b0, ifR.rd_data}; end
      3: begin curValid = ifW.rd_data_valid; curErr = ifW.rd_err; curData = {4'b0, ifW.rd_data}; end
      default: ;
    endcase
  end

  // Monitor: compare each consumed response against the expected queue.
  initial begin
    logic [8:0] exp;
    forever begin
      @(negedge clock);
      if (curValid && rdDataReady) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL rd_resp: got err=%0b data=%0d, required no response", curErr, curData);
        end else begin
          exp = expQ.pop_front();
          if ({curErr, curData} !== exp) begin
            errors++;
            $display("FAIL rd_resp dut%0d: got err=%0b data=%0d, required err=%0b data=%0d",
                     sel, curErr, curData, exp[8], exp[7:0]);
          end
        end
      end
    end
  end

  // Driver helpers.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] evMask(input int idx);
    logic [3:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  task automatic readOne(input logic [2:0] idx, input logic e, input logic [7:0] d);
    expQ.push_back({e, d});
    rdIdx = idx;
    rdReq = 1'b1;
    step();
    rdReq = 1'b0;
    step();
    step();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 16 && expQ.size() != 0; i++) step();
    check(name, expQ.size(), 0);
  endtask

  // Stimulus.
  initial begin
    resetA = 1'b1; resetS = 1'b1; resetR = 1'b1; resetW = 1'b1;
    ev = '0; en = 1'b0; clr = 1'b0; snapReq = 1'b0;
    rdReq = 1'b0; rdIdx = '0; rdDataReady = 1'b1;
    sel = 0;
    step();
    step();

    // Reset state, then basic counting on dutA.
    resetA = 1'b0; en = 1'b1; ev = evMask(EV_HIT);
    settle();
    check("rst_valid", ifA.rd_data_valid, 0);
    check("rst_ready", ifA.rd_ready, 1);
    check("rst_data", ifA.rd_data, 0);
    check("rst_err", ifA.rd_err, 0);
    check("rst_ovf", ifA.overflow, 0);
    check("rst_wdone", ifA.window_done, 0);
    repeat (5) step();
    ev = evMask(EV_READ);
    repeat (3) step();
    en = 1'b0; ev = evMask(EV_WRITE);
    repeat (2) step();
    en = 1'b1; ev = '0; snapReq = 1'b1;
    step();
    snapReq = 1'b0;

    // Back-to-back reads, one per cycle.
    rdReq = 1'b1;
    rdIdx = 3'd0; expQ.push_back({1'b0, 8'd5}); step();
    rdIdx = 3'd2; expQ.push_back({1'b0, 8'd3}); step();
    rdIdx = 3'd1; expQ.push_back({1'b0, 8'd0}); step();
    rdIdx = 3'd3; expQ.push_back({1'b0, 8'd0}); step();
    rdReq = 1'b0;

    // Clear beats a same-cycle increment; snapshot keeps the pre-clear 7.
    ev = evMask(EV_HIT);
    repeat (2) step();
    clr = 1'b1; snapReq = 1'b1;
    step();
    clr = 1'b0; ev = '0;
    // Read coinciding with a new snapshot returns the old value.
    rdReq = 1'b1; rdIdx = 3'd0; expQ.push_back({1'b0, 8'd7});
    step();
    snapReq = 1'b0;
    rdIdx = 3'd0; expQ.push_back({1'b0, 8'd0}); step();
    rdIdx = 3'd2; expQ.push_back({1'b0, 8'd0}); step();
    rdReq = 1'b0;

    // Stalled consumer: response holds, rd_ready low, pending request waits.
    ev = evMask(EV_MISS);
    repeat (4) step();
    ev = '0; snapReq = 1'b1;
    step();
    snapReq = 1'b0; rdDataReady = 1'b0;
    rdReq = 1'b1; rdIdx = 3'd1; expQ.push_back({1'b0, 8'd4});
    step();
    rdIdx = 3'd5; expQ.push_back({1'b1, 8'd0});
    for (int k = 0; k < 3; k++) begin
      settle();
      check("stall_valid", ifA.rd_data_valid, 1);
      check("stall_data", ifA.rd_data, 4);
      check("stall_err", ifA.rd_err, 0);
      check("stall_ready", ifA.rd_ready, 0);
      step();
    end
    rdDataReady = 1'b1;
    step();
    rdReq = 1'b0;
    step();
    step();

    // Reset in the middle of a held response with live count 20.
    ev = evMask(EV_HIT);
    repeat (20) step();
    ev = '0; rdDataReady = 1'b0; rdReq = 1'b1; rdIdx = 3'd0; snapReq = 1'b1;
    step();
    rdReq = 1'b0; snapReq = 1'b0;
    settle();
    check("pre_rst_valid", ifA.rd_data_valid, 1);
    resetA = 1'b1;
    step();
    settle();
    check("midrst_valid", ifA.rd_data_valid, 0);
    check("midrst_data", ifA.rd_data, 0);
    check("midrst_err", ifA.rd_err, 0);
    check("midrst_ovf", ifA.overflow, 0);
    check("midrst_ready", ifA.rd_ready, 1);
    resetA = 1'b0; rdDataReady = 1'b1;
    readOne(3'd0, 1'b0, 8'd0);
    snapReq = 1'b1;
    step();
    snapReq = 1'b0;
    readOne(3'd0, 1'b0, 8'd0);
    drain("drain_a");

    // Saturate (dutS) and wrap (dutR) run side by side.
    resetA = 1'b1; resetS = 1'b0; resetR = 1'b0; sel = 1;
    en = 1'b1; ev = evMask(EV_HIT);
    repeat (15) step();
    settle();
    check("sat_ovf_at_max", ifS.overflow, 4'b0000);
    check("wrap_ovf_at_max", ifR.overflow, 4'b0000);
    repeat (2) step();
    ev = '0;
    settle();
    check("sat_ovf", ifS.overflow, 4'b0001);
    check("wrap_ovf", ifR.overflow, 4'b0001);
    snapReq = 1'b1;
    step();
    snapReq = 1'b0;
    readOne(3'd0, 1'b0, 8'd15);
    sel = 2;
    readOne(3'd0, 1'b0, 8'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    settle();
    check("sat_ovf_clr", ifS.overflow, 4'b0000);
    check("wrap_ovf_clr", ifR.overflow, 4'b0000);
    snapReq = 1'b1;
    step();
    snapReq = 1'b0;
    readOne(3'd0, 1'b0, 8'd0);
    sel = 1;
    readOne(3'd0, 1'b0, 8'd0);
    drain("drain_sr");

    // Windowed instance with a hit every cycle.
    resetS = 1'b1; resetR = 1'b1; sel = 3;
    en = 1'b1; ev = evMask(EV_HIT); rdIdx = 3'd0;
    step();
    resetW = 1'b0;
    for (int n = 0; n < 35; n++) begin
      settle();
      check($sformatf("wdone_%0d", n), ifW.window_done, (n > 0 && n % 10 == 0) ? 1 : 0);
      if (n == 12) begin
        rdReq = 1'b1; expQ.push_back({1'b0, 8'd9});
      end else if (n == 25 || n == 32) begin
        rdReq = 1'b1; expQ.push_back({1'b0, 8'd10});
      end else begin
        rdReq = 1'b0;
      end
      step();
    end
    rdReq = 1'b0;
    drain("drain_w");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
